seg7_scan: RTL

Multiplexed seven-segment display driver: the consumer side of our BCD/hex counters (e.g. a chain of `counter10` digits). It takes `DIGITS` packed 4-bit digit values, decodes each to segments, and time-multiplexes them onto a shared segment bus with one anode strobe per digit. Each frame uses a shadow snapshot of the inputs, so a digit never tears mid-frame. It sits between counter/datapath logic and the board's display pins.

---
 rtl/seg7_scan.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment driver. A prescaler paces a digit
// index; the inputs are snapshotted into shadow registers once per frame
// so a frame never mixes old and new digits. All outputs are registered.
module seg7_scan #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 2500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dots,
  input  logic                  i_blank_lz,
  input  logic                  i_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DW-1:0]            div_cnt_q, div_cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0][3:0]   shd_data_q, shd_data_d;
  logic [DIGITS-1:0]        shd_dots_q, shd_dots_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic [DIGITS-1:0]        an_q, an_d;

  logic                     tick;
  logic                     frame_end;
  logic [DIGITS-1:0]        blank_mask;
  logic [3:0]               cur_dig;
  logic [6:0]               dec;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);
  assign cur_dig   = shd_data_q[idx_q];

  // Prescaler, digit index and frame-boundary shadow capture
  always_comb begin
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    shd_data_d = frame_end ? i_data : shd_data_q;
    shd_dots_d = frame_end ? i_dots : shd_dots_q;
  end

  // Leading-zero mask: digit k blanks when it and everything above it is zero;
  // digit 0 is never blanked so an all-zero value still reads "0"
  always_comb begin
    logic run;
    run        = i_blank_lz;
    blank_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run           = run && (shd_data_q[k] == 4'h0);
      blank_mask[k] = run;
    end
  end

  // Full hex decode, active-high, bit0 = a ... bit6 = g
  always_comb begin
    case (cur_dig)
      4'h0: dec = 7'h3F;  4'h1: dec = 7'h06;  4'h2: dec = 7'h5B;  4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;  4'h5: dec = 7'h6D;  4'h6: dec = 7'h7D;  4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h6F;  4'hA: dec = 7'h77;  4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;  4'hD: dec = 7'h5E;  4'hE: dec = 7'h79;  default: dec = 7'h71;
    endcase
  end

  // Next output image: one-hot anode, blanked/disabled segments, then polarity
  always_comb begin
    logic [DIGITS-1:0] an_hot;
    logic [6:0]        seg_on;
    logic              dp_on;
    an_hot        = '0;
    an_hot[idx_q] = 1'b1;
    seg_on        = blank_mask[idx_q] ? 7'h00 : dec;
    dp_on         = shd_dots_q[idx_q];
    if (!i_en) begin
      an_hot = '0;
      seg_on = 7'h00;
      dp_on  = 1'b0;
    end
    an_d  = an_hot ^ AN_INV;
    seg_d = seg_on ^ SEG_INV;
    dp_d  = dp_on ^ DP_INV;
  end

  // State and output registers; reset darkens the display immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dots_q <= '0;
      an_q       <= AN_INV;
      seg_q      <= SEG_INV;
      dp_q       <= DP_INV;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dots_q <= shd_dots_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule
